// File: rtl/fetch_decode_stage_if.sv
// rtl/fetch_decode_stage_if.sv - hazard, redirect, imem and IF/ID signals of the fetch/decode stage
interface fetch_decode_stage_if #(
    parameter int CNT_W = 16
);
    logic              stall_f;
    logic              stall_d;
    logic              pc_src_d;
    logic [31:0]       branch_target_d;
    logic [1:0]        sig_jump_d;
    logic [25:0]       jump_index_d;
    logic [31:0]       jr_target_d;
    logic              halt_req_d;
    logic [31:0]       imem_rdata;
    logic [31:0]       imem_addr;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pc_plus4_d;
    logic              valid_d;
    logic              halted;
    logic [CNT_W-1:0]  stall_cycles;

    // Environment view: hazard unit, decode stage and instruction memory
    modport master (
        output stall_f, stall_d, pc_src_d, branch_target_d, sig_jump_d,
               jump_index_d, jr_target_d, halt_req_d, imem_rdata,
        input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, halted, stall_cycles
    );

    // Stage view: the fetch/decode block itself
    modport slave (
        input  stall_f, stall_d, pc_src_d, branch_target_d, sig_jump_d,
               jump_index_d, jr_target_d, halt_req_d, imem_rdata,
        output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, halted, stall_cycles
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - IF stage with PC, redirect select, IF/ID register and halt FSM
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_decode_stage_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              run;
    logic              halt_go;
    logic              redirect;
    logic [31:0]       target;
    logic              unused_low_bits;

    // Target bits [1:0] are dropped to keep every fetch word-aligned
    assign unused_low_bits = ^{bus.jr_target_d[1:0], bus.branch_target_d[1:0]};

    // Redirect/halt decisions; halt wins over a simultaneous redirect so the PC stays put
    always_comb begin
        run      = (state_q == RUN);
        halt_go  = run && bus.halt_req_d && !bus.stall_d && ifid_valid_q;
        redirect = 1'b0;
        target   = {bus.branch_target_d[31:2], 2'b00};
        if (run && !bus.stall_d && !halt_go) begin
            if (bus.sig_jump_d == 2'b10) begin
                redirect = 1'b1;
                target   = {bus.jr_target_d[31:2], 2'b00};
            end else if (bus.sig_jump_d == 2'b01) begin
                redirect = 1'b1;
                target   = {ifid_pc4_q[31:28], bus.jump_index_d, 2'b00};
            end else if (bus.pc_src_d) begin
                redirect = 1'b1;
                target   = {bus.branch_target_d[31:2], 2'b00};
            end
        end
    end

    // Next-state for PC, IF/ID register, halt FSM and stall counter
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        cnt_d        = cnt_q;

        if (halt_go) begin
            state_d = HALTED;
        end

        // Redirect beats stall_f; halted or halting freezes the PC
        if (run && !halt_go) begin
            if (redirect) begin
                pc_d = target;
            end else if (!bus.stall_f) begin
                pc_d = pc_q + 32'd4;
            end
        end

        // A stalled decode slot holds even across a flush or halt
        if (!bus.stall_d) begin
            if (redirect || !run || halt_go) begin
                ifid_instr_d = 32'd0;
                ifid_pc4_d   = 32'd0;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = bus.imem_rdata;
                ifid_pc4_d   = pc_q + 32'd4;
                ifid_valid_d = 1'b1;
            end
        end

        if (run && bus.stall_f && !redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State register; reset overrides every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc_f         = pc_q;
    assign bus.instr_d      = ifid_instr_q;
    assign bus.pc_plus4_d   = ifid_pc4_q;
    assign bus.valid_d      = ifid_valid_q;
    assign bus.halted       = (state_q == HALTED);
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - scoreboard bench for fetch_decode_stage
module tb_fetch_decode_stage;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RPC   = 32'h0040_0000;

    logic clk;
    logic reset;

    fetch_decode_stage_if #(.CNT_W(CNT_W)) bus ();

    fetch_decode_stage #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      pc4;
        logic             valid;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: what the stage should hold after each edge
    logic [31:0]      m_pc, m_instr, m_pc4;
    logic             m_valid, m_halted;
    logic [CNT_W-1:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the stage presents a new state, compare it to the oldest expectation
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pc_f",         bus.pc_f,                 e.pc);
            chk("sb_imem_addr",    bus.imem_addr,            e.pc);
            chk("sb_instr_d",      bus.instr_d,              e.instr);
            chk("sb_pc_plus4_d",   bus.pc_plus4_d,           e.pc4);
            chk("sb_valid_d",      {31'd0, bus.valid_d},     {31'd0, e.valid});
            chk("sb_halted",       {31'd0, bus.halted},      {31'd0, e.halted});
            chk("sb_stall_cycles", 32'(bus.stall_cycles),    32'(e.cnt));
        end
    end

    // One clock of stimulus; the model applies the stage's rules and queues the expectation
    task automatic step(input logic rst, input logic sf, input logic sd, input logic ps,
                        input logic [31:0] bt, input logic [1:0] sj, input logic [25:0] ji,
                        input logic [31:0] jr, input logic hr, input logic [31:0] im);
        logic        take, halting;
        logic [31:0] dest;
        exp_t        e;
        @(negedge clk);
        reset               = rst;
        bus.stall_f         = sf;
        bus.stall_d         = sd;
        bus.pc_src_d        = ps;
        bus.branch_target_d = bt;
        bus.sig_jump_d      = sj;
        bus.jump_index_d    = ji;
        bus.jr_target_d     = jr;
        bus.halt_req_d      = hr;
        bus.imem_rdata      = im;

        if (rst) begin
            m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
        end else begin
            halting = !m_halted && hr && !sd && m_valid;
            take    = !m_halted && !sd && !halting && (sj == 2'b10 || sj == 2'b01 || ps);
            if (sj == 2'b10)      dest = jr & 32'hFFFF_FFFC;
            else if (sj == 2'b01) dest = (m_pc4 & 32'hF000_0000) | (32'(ji) * 4);
            else                  dest = bt & 32'hFFFF_FFFC;

            if (!m_halted && sf && !take && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;

            if (!sd) begin
                if (take || m_halted || halting) begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end else begin
                    m_instr = im; m_pc4 = m_pc + 4; m_valid = 1;
                end
            end

            if (!m_halted && !halting) begin
                if (take)     m_pc = dest;
                else if (!sf) m_pc = m_pc + 4;
            end
            if (halting) m_halted = 1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic free_run(input logic [31:0] im);
        step(0, 0, 0, 0, 32'd0, 2'b00, 26'd0, 32'd0, 0, im);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall_f = 0; bus.stall_d = 0; bus.pc_src_d = 0; bus.branch_target_d = 0;
        bus.sig_jump_d = 0; bus.jump_index_d = 0; bus.jr_target_d = 0;
        bus.halt_req_d = 0; bus.imem_rdata = 0;

        // Reset and free running fetch
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2008_0005);
        chk("reset_pc", bus.pc_f, 32'h0040_0000);
        chk("reset_valid", {31'd0, bus.valid_d}, 32'd0);
        free_run(32'h2008_0005);
        chk("run1_pc", bus.pc_f, 32'h0040_0004);
        chk("run1_instr", bus.instr_d, 32'h2008_0005);
        chk("run1_pc4", bus.pc_plus4_d, 32'h0040_0004);
        free_run(32'h2008_0005);
        chk("run2_pc", bus.pc_f, 32'h0040_0008);
        free_run(32'h2008_0005);
        free_run(32'h2008_0005);
        chk("run4_pc", bus.pc_f, 32'h0040_0010);

        // Full stall for two cycles, then release
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        chk("stall_pc", bus.pc_f, 32'h0040_0010);
        chk("stall_instr", bus.instr_d, 32'h2008_0005);
        chk("stall_cnt", 32'(bus.stall_cycles), 32'd2);
        free_run(32'h1111_1111);
        chk("release_pc", bus.pc_f, 32'h0040_0014);

        // Branch redirect, then the same request while decode is stalled
        step(0, 0, 0, 1, 32'h0040_0103, 0, 0, 0, 0, 32'h2222_2222);
        chk("br_pc", bus.pc_f, 32'h0040_0100);
        chk("br_valid", {31'd0, bus.valid_d}, 32'd0);
        chk("br_instr", bus.instr_d, 32'd0);
        step(0, 1, 1, 1, 32'h0040_0303, 0, 0, 0, 0, 32'h2222_2222);
        chk("br_stalled_pc", bus.pc_f, 32'h0040_0100);

        // jr beats branch; then j uses pc_plus4_d's top nibble
        step(0, 0, 0, 1, 32'h0040_0103, 2'b10, 0, 32'h0040_0200, 0, 32'h3333_3333);
        chk("jr_pc", bus.pc_f, 32'h0040_0200);
        free_run(32'h4444_4444);
        step(0, 0, 0, 0, 0, 2'b01, 26'h010_0040, 0, 0, 32'h5555_5555);
        chk("j_pc", bus.pc_f, 32'h0040_0100);

        // Halt at 0x00400020, stay frozen, then reset out of it
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) free_run(32'h6000_0000 + 32'(i));
        chk("pre_halt_pc", bus.pc_f, 32'h0040_0020);
        step(0, 0, 0, 1, 32'h0040_0800, 0, 0, 0, 1, 32'h7777_7777);
        chk("halt_flag", {31'd0, bus.halted}, 32'd1);
        chk("halt_pc", bus.pc_f, 32'h0040_0020);
        for (int i = 0; i < 5; i++) begin
            step(0, i[0], 0, 1, 32'h0040_0900, 2'b10, 0, 32'h0040_0A00, 1, 32'h8888_8888);
            chk("halted_valid", {31'd0, bus.valid_d}, 32'd0);
            chk("halted_pc", bus.pc_f, 32'h0040_0020);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("unhalt_pc", bus.pc_f, 32'h0040_0000);
        chk("unhalt_flag", {31'd0, bus.halted}, 32'd0);

        // Counter saturation: bring it to all-ones minus one, then three more stalls
        for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("sat_pre", 32'(bus.stall_cycles), 32'hE);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
            chk("sat_hold", 32'(bus.stall_cycles), 32'hF);
        end

        // Randomized traffic checked only through the scoreboard
        for (int i = 0; i < 800; i++) begin
            logic        r_rst, r_sf, r_sd, r_ps, r_hr;
            logic [1:0]  r_sj;
            r_rst = ($urandom_range(0, 59) == 0);
            r_sf  = ($urandom_range(0, 3) == 0);
            r_sd  = ($urandom_range(0, 4) == 0);
            r_ps  = ($urandom_range(0, 5) == 0);
            r_sj  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_hr  = ($urandom_range(0, 39) == 0);
            step(r_rst, r_sf, r_sd, r_ps, $urandom, r_sj, 26'($urandom), $urandom, r_hr, $urandom);
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Upstream neighbour of the hazard unit: the IF stage plus the IF/ID pipeline register.
- Owns the PC, selects the next PC, presents the fetch address to instruction memory and registers fetched instructions into decode.
- Obeys stall_f/stall_d from the hazard unit and applies branch/jump redirects resolved in D.
- A halt FSM freezes fetch on a syscall-exit request and lets the pipeline drain.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_f  input  1  hold PC (from hazard unit).
- stall_d  input  1  hold IF/ID register (from hazard unit).
- pc_src_d  input  1  branch in D resolved taken.
- branch_target_d  input  32  branch target computed in D.
- sig_jump_d  input  2  00 none, 01 j/jal, 10 jr, 11 reserved (treated as none).
- jump_index_d  input  26  instr[25:0] of the jump in D.
- jr_target_d  input  32  forwarded rs value for jr.
- halt_req_d  input  1  syscall-exit decoded in D.
- imem_rdata  input  32  instruction at imem_addr (combinational memory).
- imem_addr  output  32  current fetch address (= pc_f).
- pc_f  output  32  current PC.
- instr_d  output  32  instruction in D.
- pc_plus4_d  output  32  PC+4 of the instruction in D.
- valid_d  output  1  instr_d is a real instruction (0 = bubble).
- halted  output  1  halt FSM in HALTED.
- stall_cycles  output  CNT_W  saturating count of stalled fetch cycles.

Behaviour:
- Reset (reset=1 at the edge):
  - pc_f=RESET_PC, instr_d=0, pc_plus4_d=0, valid_d=0, halted=0, stall_cycles=0, FSM=RUN.
  - Reset overrides every other input.
  - Reset mid-halt or mid-stall returns to RUN at RESET_PC on the next cycle.
- Alignment: pc_f[1:0] is always 00. The low 2 bits of jr_target_d and branch_target_d are forced to 0.
- Redirect:
  - Valid only when stall_d=0 and FSM=RUN. A stalled D instruction has not finished resolving, so its redirect is ignored.
  - Priority: jr (sig_jump_d=10) → jr_target_d; then j/jal (01) → {pc_plus4_d[31:28], jump_index_d, 2'b00}; then pc_src_d → branch_target_d.
  - A valid redirect overrides stall_f: pc_f loads the target.
  - No delay slot: the instruction fetched in the same cycle is discarded (IF/ID loads a bubble).
- PC update, in RUN with no redirect: if stall_f, hold; else pc_f ← pc_f+4. Wraps modulo 2^32 with no flag.
- IF/ID update, in priority order:
  - stall_d=1: hold all of instr_d, pc_plus4_d, valid_d.
  - Else if redirect or FSM=HALTED: instr_d=0, valid_d=0, pc_plus4_d=0.
  - Else: instr_d=imem_rdata, pc_plus4_d=pc_f+4, valid_d=1.
- Halt FSM (states RUN, HALTED):
  - RUN→HALTED on halt_req_d=1 with stall_d=0 and valid_d=1; halt_req_d while stalled is ignored until the stall clears.
  - On the transition edge pc_f holds and IF/ID loads a bubble.
  - Halt beats a simultaneous redirect (no PC change).
  - In HALTED: pc_f frozen, bubbles every cycle, halted=1 from the cycle after the transition.
  - HALTED exits only via reset.
- stall_cycles:
  - Increments by 1 on each edge where FSM=RUN, stall_f=1 and no redirect occurs.
  - Saturates at all-ones; never wraps.
- Latency: imem_rdata at pc_f appears on instr_d one cycle later, absent a stall or flush.

Test Plan:
- Reset then 3 free-running cycles, imem returning 0x2008_0005 → pc_f sequence 0x00400000, 0x00400004, 0x00400008; instr_d=0x2008_0005 and valid_d=1 from cycle 1; pc_plus4_d=0x00400004 in cycle 1.
- stall_f=stall_d=1 for 2 cycles with pc_f=0x00400010 → pc_f, instr_d and valid_d unchanged for both cycles; stall_cycles 0→2; on release pc_f=0x00400014.
- pc_src_d=1, branch_target_d=0x00400103, stall_d=0 → next pc_f=0x00400100; valid_d=0 and instr_d=0 next cycle; same stimulus with stall_d=1 → no redirect, state held.
- sig_jump_d=10 with jr_target_d=0x00400200 and pc_src_d=1 simultaneously → pc_f=0x00400200 (jr wins). sig_jump_d=01, jump_index_d=0x0100040, pc_plus4_d=0x00400008 → pc_f=0x00400100.
- halt_req_d=1, valid_d=1, stall_d=0, pc_f=0x00400020 → halted=1 next cycle; pc_f stays 0x00400020; valid_d=0 for 5 further cycles; assert reset → pc_f=0x00400000, halted=0.
- Preload stall_cycles=0xFFFE, hold stall_f=1 for 3 cycles → counter reads 0xFFFF and stays there.
